// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S/LJ/TDM transmitter.
//   i2s_mode_e       - frame format encoding as seen on mode_i
//   DEF_*            - default parameter values for the transmitter and FIFO
//   is_tdm/data_lags - format helpers used by the serializer
package i2s_pkg;

  typedef enum logic [1:0] {
    MODE_I2S  = 2'd0,
    MODE_LJ   = 2'd1,
    MODE_TDM  = 2'd2,
    MODE_RSVD = 2'd3
  } i2s_mode_e;

  localparam int DEF_DATA_WIDTH  = 24;
  localparam int DEF_SLOT_WIDTH  = 32;
  localparam int DEF_CHANNEL_NUM = 8;
  localparam int DEF_FIFO_DEPTH  = 16;

  // The reserved encoding behaves exactly like TDM.
  function automatic logic is_tdm(input i2s_mode_e m);
    return (m == MODE_TDM) || (m == MODE_RSVD);
  endfunction

  // Left-justified puts the MSB on the first bit of the slot; I2S and TDM
  // delay the data by one bit time relative to the slot counter.
  function automatic logic data_lags(input i2s_mode_e m);
    return m != MODE_LJ;
  endfunction

endpackage

// File: rtl/i2s_fifo.sv
// i2s_fifo: synchronous show-ahead sample FIFO, DATA_WIDTH x FIFO_DEPTH.
//   clk_i, rst_i   - clock, asynchronous active-high reset (pointers only)
//   push_i/push_data_i - write request and data, ignored when full
//   pop_i          - read request, ignored when empty
//   pop_data_o     - entry at the read pointer (valid while !empty_o)
//   full_o, empty_o, count_o - status and occupancy
module i2s_fifo
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [DATA_WIDTH-1:0]       push_data_i,
  input  logic                        pop_i,
  output logic [DATA_WIDTH-1:0]       pop_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]           wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  do_push, do_pop;

  assign count_o    = wr_ptr - rd_ptr;
  assign full_o     = (count_o == DEPTH_L);
  assign empty_o    = (wr_ptr == rd_ptr);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: I2S / left-justified / TDM serial audio transmitter.
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   en_i          - transmit enable; mode_i/div_i are captured on its rising cycle
//   mode_i        - 0 I2S, 1 left-justified, 2/3 TDM
//   div_i         - SCK half-period in clk_i cycles minus one
//   wr_valid_i, wr_data_i, wr_ready_o, count_o - sample FIFO write side
//   underrun_o    - one-cycle pulse when a slot starts with the FIFO empty
//   sck_o, ws_o, sd_o - serial clock, word select, serial data
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SLOT_WIDTH  = DEF_SLOT_WIDTH,
  parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [1:0]                  mode_i,
  input  logic [7:0]                  div_i,
  input  logic                        wr_valid_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  output logic                        wr_ready_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        underrun_o,
  output logic                        sck_o,
  output logic                        ws_o,
  output logic                        sd_o
);

  localparam int BW   = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int SLW  = $clog2(CHANNEL_NUM);
  localparam int PADW = SLOT_WIDTH - DATA_WIDTH;
  localparam logic [BW-1:0]  BIT_LAST  = BW'(SLOT_WIDTH - 1);
  localparam logic [SLW-1:0] SLOT_LAST = SLW'(CHANNEL_NUM - 1);
  localparam logic [SLW-1:0] SLOT_HALF = SLW'(CHANNEL_NUM / 2);

  logic                  en_q;
  i2s_mode_e             mode_q, mode_eff;
  logic [7:0]            div_q, div_cnt;
  logic [BW-1:0]         bit_cnt, nxt_bit;
  logic [SLW-1:0]        slot_cnt, nxt_slot;
  logic [SLOT_WIDTH-1:0] shift_q, word_cur;
  logic                  lj_bit_q, lj_bit_d;
  logic                  start, div_wrap, fall_ev, slot_begin;
  logic                  ws_d, sd_d, underrun_d;
  logic                  fifo_empty, fifo_full, fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;

  i2s_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (wr_valid_i),
    .push_data_i (wr_data_i),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count_o)
  );

  assign wr_ready_o = !fifo_full;

  // The enable's rising cycle acts as a virtual SCK falling edge that places
  // slot 0 bit 0 on the wire; the format is taken straight from mode_i there
  // because mode_q is only loaded at the end of that cycle.
  assign start    = en_i && !en_q;
  assign mode_eff = start ? i2s_mode_e'(mode_i) : mode_q;
  assign div_wrap = en_i && !start && (div_cnt == div_q);
  assign fall_ev  = start || (div_wrap && sck_o);

  // Bit/slot position that becomes current at this falling event.
  always_comb begin
    nxt_bit  = '0;
    nxt_slot = '0;
    if (!start) begin
      if (bit_cnt == BIT_LAST) begin
        nxt_bit  = '0;
        nxt_slot = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
      end else begin
        nxt_bit  = bit_cnt + 1'b1;
        nxt_slot = slot_cnt;
      end
    end
  end

  assign slot_begin = fall_ev && (nxt_bit == '0);
  assign fifo_pop   = slot_begin && !fifo_empty;
  assign underrun_d = slot_begin && fifo_empty;

  // An empty FIFO at slot start sends an all-zero slot.
  always_comb begin
    word_cur = shift_q;
    if (slot_begin) word_cur = fifo_empty ? '0 : (SLOT_WIDTH'(fifo_data) << PADW);
  end

  // lj_bit_d is the bit a left-justified stream carries now; lagging formats
  // send the one from the previous bit time.
  assign lj_bit_d = word_cur[SLOT_WIDTH-1];
  assign sd_d     = data_lags(mode_eff) ? lj_bit_q : lj_bit_d;
  assign ws_d     = is_tdm(mode_eff) ? ((nxt_bit == '0) && (nxt_slot == '0))
                                     : (nxt_slot >= SLOT_HALF);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      mode_q     <= MODE_I2S;
      div_q      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      lj_bit_q   <= 1'b0;
      sck_o      <= 1'b0;
      ws_o       <= 1'b0;
      sd_o       <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      en_q       <= en_i;
      underrun_o <= underrun_d;
      if (start) begin
        mode_q <= i2s_mode_e'(mode_i);
        div_q  <= div_i;
      end
      if (!en_i) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        slot_cnt <= '0;
        lj_bit_q <= 1'b0;
        sck_o    <= 1'b0;
        ws_o     <= 1'b0;
        sd_o     <= 1'b0;
      end else begin
        if (start) begin
          div_cnt <= '0;
        end else if (div_wrap) begin
          div_cnt <= '0;
          sck_o   <= !sck_o;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (fall_ev) begin
          bit_cnt  <= nxt_bit;
          slot_cnt <= nxt_slot;
          lj_bit_q <= lj_bit_d;
          ws_o     <= ws_d;
          sd_o     <= sd_d;
        end
      end
    end
  end

  // Shift register holds the remaining bits of the current slot, MSB first.
  always_ff @(posedge clk_i) begin
    if (fall_ev) shift_q <= word_cur << 1;
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
`timescale 1ns/1ps
module tb_i2s_tdm_tx;

  localparam int DW = 24;
  localparam int SW = 32;
  localparam int FD = 16;
  localparam int CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [7:0]    div;
  logic [DW-1:0] wdata;
  logic          en2, en8, wv2, wv8;
  logic          rdy2, rdy8, ur2, ur8, sck2, sck8, ws2, ws8, sd2, sd8;
  logic [CW-1:0] cnt2, cnt8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int urun;
  int cap_n;
  logic [DW-1:0] q2[$];
  logic [DW-1:0] q8[$];
  logic          cap_sd [0:1023];
  logic          cap_ws [0:1023];
  int            cap_t  [0:1023];
  logic [CW-1:0] cap_cnt[0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_tdm_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CHANNEL_NUM(2), .FIFO_DEPTH(FD)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en2), .mode_i(mode), .div_i(div),
    .wr_valid_i(wv2), .wr_data_i(wdata), .wr_ready_o(rdy2), .count_o(cnt2),
    .underrun_o(ur2), .sck_o(sck2), .ws_o(ws2), .sd_o(sd2)
  );

  i2s_tdm_tx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CHANNEL_NUM(8), .FIFO_DEPTH(FD)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .en_i(en8), .mode_i(mode), .div_i(div),
    .wr_valid_i(wv8), .wr_data_i(wdata), .wr_ready_o(rdy8), .count_o(cnt8),
    .underrun_o(ur8), .sck_o(sck8), .ws_o(ws8), .sd_o(sd8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample write; accepted writes go on the scoreboard queue.
  task automatic wr(input int sel, input logic [DW-1:0] d, input bit accept);
    @(negedge clk);
    wdata = d;
    if (sel == 1) wv8 = 1'b1; else wv2 = 1'b1;
    @(negedge clk);
    wv2 = 1'b0;
    wv8 = 1'b0;
    if (accept) begin
      if (sel == 1) q8.push_back(d); else q2.push_back(d);
    end
  endtask

  // Receiver: record sd/ws/count at each SCK rising edge, count underruns.
  task automatic capture(input int sel, input int n);
    logic prev = 1'b0;
    logic s;
    int got = 0;
    int budget = n * 16 + 100;
    urun = 0;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      s = (sel == 1) ? sck8 : sck2;
      if ((sel == 1) ? ur8 : ur2) urun++;
      if (s && !prev) begin
        cap_sd[got]  = (sel == 1) ? sd8 : sd2;
        cap_ws[got]  = (sel == 1) ? ws8 : ws2;
        cap_cnt[got] = (sel == 1) ? cnt8 : cnt2;
        cap_t[got]   = cyc;
        got++;
      end
      prev = s;
    end
    cap_n = got;
    if (got < n) check("capture_timeout", got, n);
  endtask

  // Compare captured slots against the scoreboard (empty queue -> zero slot).
  task automatic check_slots(input int sel, input int nslots, input int lag,
                             input int ch, input bit tdm, input string tag);
    logic [DW-1:0]    word, exp;
    logic [SW-DW-1:0] pad;
    logic [SW-1:0]    wso, wse;
    for (int s = 0; s < nslots; s++) begin
      for (int b = 0; b < DW; b++)      word[DW-1-b]   = cap_sd[SW*s + lag + b];
      for (int b = 0; b < SW - DW; b++) pad[SW-DW-1-b] = cap_sd[SW*s + lag + DW + b];
      for (int b = 0; b < SW; b++)      wso[SW-1-b]    = cap_ws[SW*s + b];
      exp = '0;
      if (sel == 1) begin
        if (q8.size() > 0) exp = q8.pop_front();
      end else begin
        if (q2.size() > 0) exp = q2.pop_front();
      end
      if (tdm) wse = ((s % ch) == 0) ? {1'b1, {(SW-1){1'b0}}} : '0;
      else     wse = ((s % ch) >= ch / 2) ? '1 : '0;
      check($sformatf("%s_slot%0d_data", tag, s), word, exp);
      check($sformatf("%s_slot%0d_pad", tag, s), pad, 0);
      check($sformatf("%s_slot%0d_ws", tag, s), wso, wse);
    end
  endtask

  initial begin
    int nws;
    rst = 1'b1; en2 = 1'b0; en8 = 1'b0; wv2 = 1'b0; wv8 = 1'b0;
    mode = 2'd0; div = 8'd0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_dut2", {cnt2, rdy2, sck2, ws2, sd2, ur2}, {CW'(0), 1'b1, 4'b0});
    check("reset_dut8", {cnt8, rdy8, sck8, ws8, sd8, ur8}, {CW'(0), 1'b1, 4'b0});
    rst = 1'b0;
    @(negedge clk);

    // I2S, 2 channels, div 1
    wr(0, 24'hA5A5A5, 1);
    wr(0, 24'h5A5A5A, 1);
    check("t1_count", cnt2, 2);
    mode = 2'd0; div = 8'd1; en2 = 1'b1;
    capture(0, 2*SW + 1);
    check("t1_sck_period", cap_t[1] - cap_t[0], 4);
    check_slots(0, 2, 1, 2, 0, "t1");
    en2 = 1'b0;
    @(negedge clk);
    check("t1_disable_low", {sck2, ws2, sd2}, 0);

    // TDM, 8 channels, div 0
    for (int i = 1; i <= 8; i++) wr(1, DW'(i), 1);
    mode = 2'd2; div = 8'd0; en8 = 1'b1;
    capture(1, 2*8*SW + 2);
    check("t2_sck_period", cap_t[1] - cap_t[0], 2);
    check_slots(1, 8, 1, 8, 1, "t2");
    nws = 0;
    for (int i = 0; i < 2*8*SW; i++) nws += int'(cap_ws[i]);
    check("t2_ws_pulse_count", nws, 2);
    check("t2_ws_second_frame", cap_ws[8*SW], 1);
    en8 = 1'b0;
    @(negedge clk);

    // Left-justified, one sample for two slots
    wr(0, 24'h123456, 1);
    mode = 2'd1; div = 8'd0; en2 = 1'b1;
    capture(0, 2*SW);
    check_slots(0, 2, 0, 2, 0, "t3");
    check("t3_underrun_pulses", urun, 1);
    en2 = 1'b0;
    @(negedge clk);

    // Fill FIFO while disabled, overflow write, then drain
    for (int i = 0; i < 16; i++) wr(1, 24'h100000 + DW'(i * 24'h1357), 1);
    check("t4_count_full", cnt8, 16);
    check("t4_ready_full", rdy8, 0);
    wr(1, 24'hDEAD00, 0);
    check("t4_count_after_17th", cnt8, 16);
    mode = 2'd2; div = 8'd0; en8 = 1'b1;
    capture(1, 16*SW + 1);
    check("t4_count_slot0", cap_cnt[0], 15);
    check("t4_count_slot1", cap_cnt[SW], 14);
    check_slots(1, 16, 1, 8, 1, "t4");
    check("t4_count_empty", cnt8, 0);
    en8 = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of slot 3
    for (int i = 0; i < 8; i++) wr(1, 24'hC00000 + DW'(i), 1);
    mode = 2'd0; div = 8'd0; en8 = 1'b1;
    capture(1, 3*SW + 10);
    check_slots(1, 3, 1, 8, 0, "t5");
    check("t5_sck_high_before_reset", sck8, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_reset", {sck8, ws8, sd8, ur8, cnt8, rdy8}, {4'b0, CW'(0), 1'b1});
    q8.delete();
    en8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr(1, 24'h0BEEF1, 1);
    wr(1, 24'h0CAFE2, 1);
    mode = 2'd0; div = 8'd0; en8 = 1'b1;
    capture(1, 2*SW + 1);
    check_slots(1, 2, 1, 8, 0, "t5_restart");
    en8 = 1'b0;
    @(negedge clk);

    // mode/div changes while enabled are ignored until the next enable
    wr(0, 24'h654321, 1);
    wr(0, 24'h0F0F0F, 1);
    mode = 2'd1; div = 8'd0; en2 = 1'b1;
    @(negedge clk);
    mode = 2'd0; div = 8'd3;
    capture(0, 2*SW);
    check("t6_period_latched", cap_t[1] - cap_t[0], 2);
    check_slots(0, 2, 0, 2, 0, "t6_lj");
    en2 = 1'b0;
    @(negedge clk);
    wr(0, 24'h777777, 1);
    wr(0, 24'h888888, 1);
    en2 = 1'b1;
    capture(0, 2*SW + 1);
    check("t6_period_new", cap_t[1] - cap_t[0], 8);
    check_slots(0, 2, 1, 2, 0, "t6_i2s");
    en2 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_tx.md
I2S_TDM_TX -- requirements
Module: i2s_tdm_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning sample bits per slot.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32, meaning SCK periods per slot (SLOT_WIDTH >= DATA_WIDTH).
REQ-003 SHALL have parameter CHANNEL_NUM, default 8, meaning slots per frame (even, 2..16).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning sample FIFO entries (power of two).
REQ-005 SHALL have port clk_i  input  1  the single clock, all logic rising-edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-007 SHALL have port en_i  input  1  transmit enable.
REQ-008 SHALL have port mode_i  input  2  frame format: 0 I2S, 1 left-justified, 2 TDM, 3 reserved (treated as TDM).
REQ-009 SHALL have port div_i  input  8  SCK half-period in clk_i cycles minus one.
REQ-010 SHALL have port wr_valid_i  input  1  sample write request.
REQ-011 SHALL have port wr_data_i  input  DATA_WIDTH  sample, channel order slot0..slotN-1.
REQ-012 SHALL have port wr_ready_o  output  1  FIFO can accept a sample.
REQ-013 SHALL have port count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port underrun_o  output  1  one-cycle pulse on slot start with empty FIFO.
REQ-015 SHALL have ports sck_o, ws_o, sd_o  output  1 each  serial clock, word select, serial data.

Function
REQ-016 SHALL push wr_data_i when wr_valid_i && wr_ready_o; wr_ready_o = !full; push and pop in the same cycle SHALL both occur, count unchanged.
REQ-017 SHALL latch mode_i and div_i on the en_i 0->1 cycle; changes while enabled SHALL be ignored.
REQ-018 SHALL run a divider counter 0..div_i; on wrap sck_o toggles; sck_o idles low.
REQ-019 SHALL update ws_o and sd_o only on sck_o falling events (high->low toggle), plus the virtual falling event in the first enabled cycle; receiver samples on rising.
REQ-020 SHALL track bit counter 0..SLOT_WIDTH-1 and slot counter 0..CHANNEL_NUM-1, both wrapping; slot wrap ends a frame.
REQ-021 SHALL pop one sample at each slot's first bit; sample shifted MSB-first, followed by SLOT_WIDTH-DATA_WIDTH zero bits.
REQ-022 SHALL, on slot start with FIFO empty, transmit all-zero slot and pulse underrun_o for one clk_i cycle; frame timing unaffected.
REQ-023 I2S mode: ws_o low for slots 0..CHANNEL_NUM/2-1, high otherwise; sd_o lags ws_o transitions by one SCK period (MSB at second bit time).
REQ-024 Left-justified mode: same ws_o as I2S, MSB coincident with ws_o transition.
REQ-025 TDM mode: ws_o high for exactly one SCK period, the last bit time of the previous frame (first frame: ws_o high during bit 0, MSB at bit 1).
REQ-026 SHALL, on en_i deassert, within one cycle drive sck_o, ws_o, sd_o low and clear divider/bit/slot counters; FIFO contents retained.
REQ-027 SHALL not pop while en_i low; writes remain accepted.

Reset
REQ-028 SHALL on rst_i asynchronously clear FIFO pointers (count_o=0, wr_ready_o=1) and drive sck_o=0, ws_o=0, sd_o=0, underrun_o=0, all counters 0.
REQ-029 SHALL, on reset mid-frame, abandon the frame; after release the next enable starts at slot 0 bit 0.

Structure
REQ-030 SHALL place mode encodings (I2S/LJ/TDM enum) and default parameter constants in shared package i2s_pkg, alongside existing i2s_define.sv content.
REQ-031 SHALL instantiate one sub-module i2s_fifo (synchronous FIFO, DATA_WIDTH x FIFO_DEPTH, asynchronous active-high reset).

Verification
REQ-032 I2S, CHANNEL_NUM=2, DATA_WIDTH=24, SLOT_WIDTH=32, div_i=1, write 0xA5A5A5, 0x5A5A5A -> left slot MSB one SCK after ws_o falls, 8 zero pad bits, SCK period 4 clk_i.
REQ-033 TDM, CHANNEL_NUM=8, write 1..8 -> ws_o one-SCK pulse per 256 SCK; slot k carries k+1 MSB-first.
REQ-034 Left-justified, FIFO holds 1 sample, 2 slots -> slot1 all zero, underrun_o pulses exactly once.
REQ-035 Fill FIFO_DEPTH=16 while disabled -> count_o=16, wr_ready_o=0; 17th write ignored; enable -> pop each slot, count_o decrements.
REQ-036 Assert rst_i mid-slot 3 -> outputs low within the same cycle asynchronously, count_o=0; re-enable starts slot 0.
REQ-037 Change mode_i while enabled -> format unchanged until en_i toggles.
